fll_cfg_ctrl: RTL and testbench
===============================

Name: fll_cfg_ctrl

Overview:
- Sequences and shares the FLL configuration port (req/ack, 2-bit address, 32-bit data, write-enable-low) in the clock/reset generator.
- After reset it autonomously programs two boot configuration words and waits for FLL lock, with a timeout.
- It then switches the clock mux to the FLL clock and hands the config port to a software requester.
- Sits between the SoC peripheral bus and the clock/reset generator's fll_* pins, in the reference-clock domain.

Parameters:
- BOOT_CFG1, 32'h0000_0000, data written to FLL address 2'd1 at boot.
- BOOT_CFG2, 32'h0000_0000, data written to FLL address 2'd2 at boot.
- LOCK_TIMEOUT, 16'd4096, cycles to wait for synchronised lock before flagging an error; legal range 1..65535.
- AUTO_BOOT, 1, 1 = run the boot sequence after reset; 0 = go straight to IDLE with clk_sel_o=0.

Ports:
- clk_i  in  1  reference clock.
- rstn_i  in  1  asynchronous active-low reset.
- sw_req_i  in  1  software request; held high with sw_wrn_i, sw_add_i, sw_data_i stable until sw_gnt_o.
- sw_wrn_i  in  1  0 = write, 1 = read.
- sw_add_i  in  2  FLL register address.
- sw_data_i  in  32  write data.
- sw_gnt_o  out  1  one-cycle completion pulse.
- sw_rdata_o  out  32  read data; valid with sw_gnt_o and held until the next completion.
- fll_req_o  out  1  FLL config request.
- fll_wrn_o  out  1  FLL write-enable-low.
- fll_add_o  out  2  FLL address.
- fll_data_o  out  32  FLL write data.
- fll_ack_i  in  1  FLL ack; asynchronous to clk_i.
- fll_r_data_i  in  32  FLL read data; stable while ack is high.
- fll_lock_i  in  1  FLL lock; asynchronous to clk_i.
- clk_sel_o  out  1  clock mux select (1 = FLL clock).
- boot_done_o  out  1  boot sequence finished, whether locked or timed out.
- lock_err_o  out  1  sticky lock-timeout flag.

Behaviour:
- Reset values: all outputs 0.
  - fll_wrn_o resets to 1.
  - FSM resets to BOOT1 if AUTO_BOOT=1, else IDLE.
  - If AUTO_BOOT=0, boot_done_o resets to 1.
- Synchronisers: fll_ack_i and fll_lock_i each pass through 2 flops to give ack_s and lock_s. All decisions use only ack_s and lock_s.
- Four-phase handshake with the FLL:
  - fll_req_o rises together with the registered fll_add_o, fll_data_o and fll_wrn_o.
  - fll_req_o and all fields stay constant while fll_req_o=1.
  - fll_req_o drops on the cycle after ack_s=1 is seen.
  - No new request is issued until ack_s=0.
  - On the cycle ack_s=1 is first seen, fll_r_data_i is captured into a 32-bit register.
- FSM states: BOOT1, BOOT2, WAIT_LOCK, IDLE, REQ, REL.
  - BOOT1/BOOT2: issue write (wrn=0) to addr 1 / addr 2 with BOOT_CFG1 / BOOT_CFG2. Each runs through REQ and REL via an internal owner tag (BOOT1, BOOT2, SW).
  - After REL of BOOT2: enter WAIT_LOCK and load the timeout counter with LOCK_TIMEOUT.
  - WAIT_LOCK: if lock_s=1, set clk_sel_o=1 and boot_done_o=1 on the next edge, then go to IDLE. Otherwise decrement the counter. When the counter reaches 0, set lock_err_o=1 and boot_done_o=1, leave clk_sel_o=0, and go to IDLE.
  - If lock_s and counter expiry coincide, lock wins.
  - IDLE: if sw_req_i=1, latch the sw fields and go to REQ with owner SW. sw_req_i is ignored in every non-IDLE state; software stalls during boot.
  - REL with owner SW: when ack_s=0, pulse sw_gnt_o for one cycle, update sw_rdata_o (captured data for reads; unchanged for writes), and return to IDLE.
- sw_req_i still high after sw_gnt_o: IDLE starts a new transaction on the following cycle. At most one transaction per 2 + sync-latency cycles.
- clk_sel_o and lock_err_o are set only by the boot sequence and never clear except by reset. A later loss of lock does not change clk_sel_o.
- Reset mid-transaction: all outputs return to reset values asynchronously, including fll_req_o=0 immediately. The boot sequence restarts after rstn_i rises.
- No timeout on ack: the FSM waits indefinitely in REQ or REL.

Test Plan:
- Reset/idle: hold rstn_i=0 -> fll_req_o=0, fll_wrn_o=1, clk_sel_o=0, sw_gnt_o=0, lock_err_o=0.
- Boot, BOOT_CFG1=32'h0000_1234, BOOT_CFG2=32'h0000_ABCD, FLL model acks 3 cycles after req and drops ack 3 cycles after req falls:
  - Required: write addr1 32'h1234, then write addr2 32'hABCD, with no overlap and req low before ack low.
  - Raise lock 10 cycles later -> clk_sel_o=1 and boot_done_o=1 exactly 3 cycles after the lock edge.
- Timeout, LOCK_TIMEOUT=16 and lock held 0 -> lock_err_o=1 and boot_done_o=1 17 cycles after WAIT_LOCK entry; clk_sel_o stays 0.
- Software read after boot, sw_add_i=2'd3, model returns 32'hDEADBEEF -> fll_wrn_o=1, fll_add_o=3, single sw_gnt_o pulse, sw_rdata_o=32'hDEADBEEF.
- Software write asserted during boot -> no fll_req_o for it until boot_done_o=1. It then completes with fll_data_o equal to the sw data.
- Reset asserted while fll_req_o=1 during BOOT2 -> fll_req_o=0 asynchronously. After release, BOOT1 restarts with addr 1.

Source files
------------

// File: rtl/fll_cfg_ctrl.sv
// fll_cfg_ctrl: owns the FLL configuration port. After reset it writes two
// boot words, waits for lock (with a timeout), switches the clock mux over to
// the FLL and then serves single software transactions on the same port.
module fll_cfg_ctrl #(
  parameter logic [31:0] BOOT_CFG1    = 32'h0000_0000,
  parameter logic [31:0] BOOT_CFG2    = 32'h0000_0000,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd4096,
  parameter bit          AUTO_BOOT    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sw_req_i,
  input  logic        sw_wrn_i,
  input  logic [1:0]  sw_add_i,
  input  logic [31:0] sw_data_i,
  output logic        sw_gnt_o,
  output logic [31:0] sw_rdata_o,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  input  logic        fll_lock_i,
  output logic        clk_sel_o,
  output logic        boot_done_o,
  output logic        lock_err_o
);

  typedef enum logic [2:0] {
    ST_BOOT1, ST_BOOT2, ST_WAIT_LOCK, ST_IDLE, ST_REQ, ST_REL
  } state_t;

  typedef enum logic [1:0] {
    OWN_BOOT1, OWN_BOOT2, OWN_SW
  } owner_t;

  localparam state_t RESET_STATE = AUTO_BOOT ? ST_BOOT1 : ST_IDLE;
  localparam logic   RESET_DONE  = AUTO_BOOT ? 1'b0 : 1'b1;

  logic ack_meta, ack_s;
  logic lock_meta, lock_s;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        req_q, req_d;
  logic        wrn_q, wrn_d;
  logic [1:0]  add_q, add_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cap_q, cap_d;
  logic [15:0] cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic [31:0] sw_rdata_q, sw_rdata_d;
  logic        clk_sel_q, clk_sel_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Two-flop synchronisers for the FLL-domain ack and lock signals
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_meta  <= 1'b0;
      ack_s     <= 1'b0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      ack_meta  <= fll_ack_i;
      ack_s     <= ack_meta;
      lock_meta <= fll_lock_i;
      lock_s    <= lock_meta;
    end
  end

  // State register plus all registered outputs; everything resets asynchronously
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RESET_STATE;
      owner_q    <= OWN_BOOT1;
      req_q      <= 1'b0;
      wrn_q      <= 1'b1;
      add_q      <= 2'd0;
      data_q     <= 32'h0;
      cap_q      <= 32'h0;
      cnt_q      <= 16'd0;
      gnt_q      <= 1'b0;
      sw_rdata_q <= 32'h0;
      clk_sel_q  <= 1'b0;
      done_q     <= RESET_DONE;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      wrn_q      <= wrn_d;
      add_q      <= add_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      sw_rdata_q <= sw_rdata_d;
      clk_sel_q  <= clk_sel_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: boot writes, lock wait, then the shared four-phase handshake
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    wrn_d      = wrn_q;
    add_d      = add_q;
    data_d     = data_q;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    gnt_d      = 1'b0;
    sw_rdata_d = sw_rdata_q;
    clk_sel_d  = clk_sel_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      ST_BOOT1: begin
        if (!ack_s) begin
          req_d   = 1'b1;
          wrn_d   = 1'b0;
          add_d   = 2'd1;
          data_d  = BOOT_CFG1;
          owner_d = OWN_BOOT1;
          state_d = ST_REQ;
        end
      end
      ST_BOOT2: begin
        if (!ack_s) begin
          req_d   = 1'b1;
          wrn_d   = 1'b0;
          add_d   = 2'd2;
          data_d  = BOOT_CFG2;
          owner_d = OWN_BOOT2;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          cap_d   = fll_r_data_i;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
          case (owner_q)
            OWN_BOOT1: state_d = ST_BOOT2;
            OWN_BOOT2: begin
              cnt_d   = LOCK_TIMEOUT;
              state_d = ST_WAIT_LOCK;
            end
            default: begin
              gnt_d = 1'b1;
              if (wrn_q) begin
                sw_rdata_d = cap_q;
              end
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          clk_sel_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == 16'd0) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_IDLE: begin
        if (sw_req_i && !ack_s) begin
          req_d   = 1'b1;
          wrn_d   = sw_wrn_i;
          add_d   = sw_add_i;
          data_d  = sw_data_i;
          owner_d = OWN_SW;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sw_gnt_o    = gnt_q;
  assign sw_rdata_o  = sw_rdata_q;
  assign fll_req_o   = req_q;
  assign fll_wrn_o   = wrn_q;
  assign fll_add_o   = add_q;
  assign fll_data_o  = data_q;
  assign clk_sel_o   = clk_sel_q;
  assign boot_done_o = done_q;
  assign lock_err_o  = err_q;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// tb_fll_cfg_ctrl: directed bench for fll_cfg_ctrl with an FLL responder,
// a cycle-level expectation model of the boot outcome and software grants,
// and a per-cycle compare process.
module tb_fll_cfg_ctrl;

  localparam logic [31:0] CFG1 = 32'h0000_1234;
  localparam logic [31:0] CFG2 = 32'h0000_ABCD;
  localparam int          TMO  = 16;

  logic        clk_i;
  logic        rstn_i;
  logic        sw_req_i;
  logic        sw_wrn_i;
  logic [1:0]  sw_add_i;
  logic [31:0] sw_data_i;
  logic        sw_gnt_o;
  logic [31:0] sw_rdata_o;
  logic        fll_req_o;
  logic        fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack_i;
  logic [31:0] fll_r_data_i;
  logic        fll_lock_i;
  logic        clk_sel_o;
  logic        boot_done_o;
  logic        lock_err_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fll_cfg_ctrl #(
    .BOOT_CFG1   (CFG1),
    .BOOT_CFG2   (CFG2),
    .LOCK_TIMEOUT(16'd16),
    .AUTO_BOOT   (1'b1)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sw_req_i    (sw_req_i),
    .sw_wrn_i    (sw_wrn_i),
    .sw_add_i    (sw_add_i),
    .sw_data_i   (sw_data_i),
    .sw_gnt_o    (sw_gnt_o),
    .sw_rdata_o  (sw_rdata_o),
    .fll_req_o   (fll_req_o),
    .fll_wrn_o   (fll_wrn_o),
    .fll_add_o   (fll_add_o),
    .fll_data_o  (fll_data_o),
    .fll_ack_i   (fll_ack_i),
    .fll_r_data_i(fll_r_data_i),
    .fll_lock_i  (fll_lock_i),
    .clk_sel_o   (clk_sel_o),
    .boot_done_o (boot_done_o),
    .lock_err_o  (lock_err_o)
  );

  // Free-running reference clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Edge counter: after posedge k, cyc == k
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic noteTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait expired (cycle %0d)", name, cyc);
  endtask

  // FLL responder model state and transaction log (cleared by reset)
  logic [31:0] fll_mem [4];
  logic        log_wrn  [$];
  logic [1:0]  log_add  [$];
  logic [31:0] log_data [$];
  logic        log_done [$];
  int          start_q  [$];
  int          fall_q   [$];
  int          entry_cyc = -1;
  int          lock_dec  = -1;
  int          gnt_due   = -1;
  logic        prev_lock = 1'b0;
  logic        sw_last_read = 1'b0;
  logic [31:0] sw_last_data = 32'h0;

  // FLL responder: ack 3 cycles after req, drop ack 3 cycles after req falls
  initial begin : fll_model
    int phase;
    int n;
    int idx;
    phase = 0;
    n = 0;
    fll_ack_i = 1'b0;
    fll_r_data_i = 32'h0;
    fll_mem[0] = 32'h0;
    fll_mem[1] = 32'h0;
    fll_mem[2] = 32'h0;
    fll_mem[3] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rstn_i) begin
        phase = 0;
        fll_ack_i = 1'b0;
        log_wrn.delete();
        log_add.delete();
        log_data.delete();
        log_done.delete();
        start_q.delete();
        fall_q.delete();
        entry_cyc = -1;
        lock_dec = -1;
        gnt_due = -1;
        prev_lock = 1'b0;
      end else begin
        // lock first taken by the sync flop at this edge -> decision two edges on
        if (fll_lock_i && !prev_lock && lock_dec < 0) lock_dec = cyc + 2;
        prev_lock = fll_lock_i;
        case (phase)
          0: begin
            if (fll_req_o) begin
              log_wrn.push_back(fll_wrn_o);
              log_add.push_back(fll_add_o);
              log_data.push_back(fll_data_o);
              log_done.push_back(boot_done_o);
              start_q.push_back(cyc);
              phase = 1;
              n = 0;
            end
          end
          1: begin
            n++;
            if (n == 3) begin
              if (!fll_wrn_o) fll_mem[fll_add_o] = fll_data_o;
              fll_r_data_i = fll_wrn_o ? fll_mem[fll_add_o] : 32'h0;
              sw_last_read = fll_wrn_o;
              sw_last_data = fll_r_data_i;
              fll_ack_i = 1'b1;
              phase = 2;
            end
          end
          2: begin
            if (!fll_req_o) begin
              phase = 3;
              n = 0;
            end
          end
          default: begin
            n++;
            if (n == 3) begin
              fll_ack_i = 1'b0;
              fall_q.push_back(cyc);
              idx = fall_q.size() - 1;
              // ack low is seen through two sync flops, acted on at the third edge
              if (idx == 1) entry_cyc = cyc + 3;
              else if (idx >= 2) gnt_due = cyc + 3;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Per-cycle compare of every DUT output against the expectation model
  logic [31:0] exp_rdata = 32'h0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        hold_wrn;
  logic [1:0]  hold_add;
  logic [31:0] hold_data;

  always @(negedge clk_i) begin : compare
    int   tmo;
    int   le;
    int   done_c;
    logic won;
    logic e_done;
    logic e_gnt;
    if (!rstn_i) begin
      checkOutput("rst_req",   32'(fll_req_o),   32'd0);
      checkOutput("rst_wrn",   32'(fll_wrn_o),   32'd1);
      checkOutput("rst_sel",   32'(clk_sel_o),   32'd0);
      checkOutput("rst_err",   32'(lock_err_o),  32'd0);
      checkOutput("rst_done",  32'(boot_done_o), 32'd0);
      checkOutput("rst_gnt",   32'(sw_gnt_o),    32'd0);
      checkOutput("rst_rdata", sw_rdata_o,       32'd0);
      exp_rdata = 32'h0;
    end else begin
      done_c = -1;
      won = 1'b0;
      if (entry_cyc >= 0) begin
        tmo = entry_cyc + TMO + 1;
        done_c = tmo;
        if (lock_dec >= 0) begin
          le = (lock_dec > entry_cyc) ? lock_dec : entry_cyc + 1;
          if (le <= tmo) begin
            done_c = le;
            won = 1'b1;
          end
        end
      end
      e_done = (done_c >= 0) && (cyc >= done_c);
      e_gnt = (gnt_due >= 0) && (cyc == gnt_due);
      if (e_gnt && sw_last_read) exp_rdata = sw_last_data;
      checkOutput("cyc_done",  32'(boot_done_o), 32'(e_done));
      checkOutput("cyc_sel",   32'(clk_sel_o),   32'(e_done && won));
      checkOutput("cyc_err",   32'(lock_err_o),  32'(e_done && !won));
      checkOutput("cyc_gnt",   32'(sw_gnt_o),    32'(e_gnt));
      checkOutput("cyc_rdata", sw_rdata_o,       exp_rdata);
      if (fll_req_o && !prev_req) begin
        checkOutput("req_while_ack", 32'(fll_ack_i), 32'd0);
        hold_wrn = fll_wrn_o;
        hold_add = fll_add_o;
        hold_data = fll_data_o;
      end else if (fll_req_o && prev_req) begin
        checkOutput("hold_wrn",  32'(fll_wrn_o), 32'(hold_wrn));
        checkOutput("hold_add",  32'(fll_add_o), 32'(hold_add));
        checkOutput("hold_data", fll_data_o,     hold_data);
      end
      if (prev_ack && !fll_ack_i) checkOutput("req_before_ack_low", 32'(fll_req_o), 32'd0);
    end
    prev_req = fll_req_o;
    prev_ack = fll_ack_i;
  end

  task automatic waitNeg(input int t);
    do @(negedge clk_i); while (cyc < t);
  endtask

  task automatic waitFall(input int idx, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (fall_q.size() > idx) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) noteTimeout("wait_ack_fall");
  endtask

  task automatic waitStart(input int idx, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (start_q.size() > idx) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) noteTimeout("wait_req_start");
  endtask

  // One software transaction: hold the request until the grant pulse
  task automatic applyStimulus(input logic wrn, input logic [1:0] add, input logic [31:0] data,
                               output logic ok, output int gcyc);
    @(negedge clk_i);
    sw_wrn_i = wrn;
    sw_add_i = add;
    sw_data_i = data;
    sw_req_i = 1'b1;
    ok = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (sw_gnt_o) begin
        ok = 1'b1;
        gcyc = cyc;
        break;
      end
    end
    sw_req_i = 1'b0;
    if (!ok) noteTimeout("wait_sw_gnt");
  endtask

  // Directed sequence
  initial begin : main
    logic ok;
    logic ok2;
    int   c;
    int   l;
    int   g;
    int   g2;
    int   k;
    rstn_i = 1'b1;
    sw_req_i = 1'b0;
    sw_wrn_i = 1'b0;
    sw_add_i = 2'd0;
    sw_data_i = 32'h0;
    fll_lock_i = 1'b0;
    #1 rstn_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("reset_req", 32'(fll_req_o), 32'd0);
    checkOutput("reset_wrn", 32'(fll_wrn_o), 32'd1);
    checkOutput("reset_sel", 32'(clk_sel_o), 32'd0);
    checkOutput("reset_gnt", 32'(sw_gnt_o),  32'd0);
    checkOutput("reset_err", 32'(lock_err_o), 32'd0);
    #1 rstn_i = 1'b1;

    $display("[TB] boot with lock");
    waitFall(1, 300, ok);
    if (ok) begin
      checkOutput("boot1_wrn",  32'(log_wrn[0]), 32'd0);
      checkOutput("boot1_add",  32'(log_add[0]), 32'd1);
      checkOutput("boot1_data", log_data[0],     32'h0000_1234);
      checkOutput("boot2_wrn",  32'(log_wrn[1]), 32'd0);
      checkOutput("boot2_add",  32'(log_add[1]), 32'd2);
      checkOutput("boot2_data", log_data[1],     32'h0000_ABCD);
      checkOutput("boot_spacing", 32'(start_q[1] - start_q[0]), 32'd13);
      c = fall_q[1];
      waitNeg(c + 10);
      fll_lock_i = 1'b1;
      l = c + 10;
      waitNeg(l + 2);
      checkOutput("lock_sel_early",  32'(clk_sel_o),   32'd0);
      checkOutput("lock_done_early", 32'(boot_done_o), 32'd0);
      waitNeg(l + 3);
      checkOutput("lock_sel",  32'(clk_sel_o),   32'd1);
      checkOutput("lock_done", 32'(boot_done_o), 32'd1);
      checkOutput("lock_err",  32'(lock_err_o),  32'd0);
      @(negedge clk_i);
      fll_lock_i = 1'b0;
      repeat (10) @(negedge clk_i);
      checkOutput("sel_sticky", 32'(clk_sel_o), 32'd1);
    end

    $display("[TB] software read addr 3");
    applyStimulus(1'b1, 2'd3, 32'h0, ok, g);
    if (ok) begin
      k = start_q.size() - 1;
      checkOutput("rd_wrn",     32'(log_wrn[k]), 32'd1);
      checkOutput("rd_add",     32'(log_add[k]), 32'd3);
      checkOutput("rd_rdata",   sw_rdata_o,      32'hDEAD_BEEF);
      checkOutput("rd_latency", 32'(g - start_q[k]), 32'd12);
      @(negedge clk_i);
      checkOutput("rd_gnt_single", 32'(sw_gnt_o), 32'd0);
    end

    $display("[TB] software write then read back addr 0");
    applyStimulus(1'b0, 2'd0, 32'h5555_AAAA, ok, g);
    if (ok) begin
      k = start_q.size() - 1;
      checkOutput("wr_wrn",   32'(log_wrn[k]), 32'd0);
      checkOutput("wr_add",   32'(log_add[k]), 32'd0);
      checkOutput("wr_data",  log_data[k],     32'h5555_AAAA);
      checkOutput("wr_rdata_held", sw_rdata_o, 32'hDEAD_BEEF);
    end
    applyStimulus(1'b1, 2'd0, 32'h0, ok, g);
    if (ok) checkOutput("rd0_rdata", sw_rdata_o, 32'h5555_AAAA);

    $display("[TB] reset after lock, then reset during BOOT2");
    @(negedge clk_i);
    #1 rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst2_sel",  32'(clk_sel_o),   32'd0);
    checkOutput("rst2_done", 32'(boot_done_o), 32'd0);
    #1 rstn_i = 1'b1;
    waitStart(1, 300, ok);
    if (ok) begin
      @(negedge clk_i);
      checkOutput("boot2_req_high", 32'(fll_req_o), 32'd1);
      checkOutput("boot2_req_add",  32'(fll_add_o), 32'd2);
      #1 rstn_i = 1'b0;
      #1;
      checkOutput("async_req", 32'(fll_req_o), 32'd0);
      checkOutput("async_wrn", 32'(fll_wrn_o), 32'd1);
      checkOutput("async_add", 32'(fll_add_o), 32'd0);
      repeat (3) @(negedge clk_i);
      #1 rstn_i = 1'b1;
    end

    $display("[TB] restart, timeout, software write queued during boot");
    fork
      applyStimulus(1'b0, 2'd2, 32'h0BAD_F00D, ok2, g2);
      begin
        waitFall(1, 300, ok);
        if (ok) begin
          checkOutput("restart_add",  32'(log_add[0]), 32'd1);
          checkOutput("restart_data", log_data[0],     32'h0000_1234);
          c = fall_q[1];
          waitNeg(c + 19);
          checkOutput("tmo_err_early",  32'(lock_err_o),  32'd0);
          checkOutput("tmo_done_early", 32'(boot_done_o), 32'd0);
          waitNeg(c + 20);
          checkOutput("tmo_err",  32'(lock_err_o),  32'd1);
          checkOutput("tmo_done", 32'(boot_done_o), 32'd1);
          checkOutput("tmo_sel",  32'(clk_sel_o),   32'd0);
        end
      end
    join
    if (ok2 && start_q.size() > 2) begin
      checkOutput("swb_wrn",  32'(log_wrn[2]),  32'd0);
      checkOutput("swb_add",  32'(log_add[2]),  32'd2);
      checkOutput("swb_data", log_data[2],      32'h0BAD_F00D);
      checkOutput("swb_after_done", 32'(log_done[2]), 32'd1);
      checkOutput("swb_after_tmo",  32'(start_q[2] > fall_q[1] + 20), 32'd1);
      checkOutput("swb_err_kept",   32'(lock_err_o), 32'd1);
    end

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
